// File: rtl/hold_reg_bank.sv
// Bank of CHANNELS holding registers, each with a one-cycle registered read port and per-channel valid flags.
// Optional overrun detection is enabled by defining HOLD_REG_OVERRUN_EN.
module hold_reg_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       ld_en,
  input  logic [CHANNELS*WIDTH-1:0] ld_data,
  input  logic                      rd_en,
  input  logic [SEL_W-1:0]          rd_sel,
  input  logic                      ovr_clr,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      rd_valid,
  output logic [CHANNELS-1:0]       valid,
  output logic [CHANNELS-1:0]       overrun,
  output logic                      any_valid
);

  localparam int unsigned NCH = CHANNELS;

  logic [WIDTH-1:0]    chan [CHANNELS];
  logic [CHANNELS-1:0] rd_mask;
  logic [WIDTH-1:0]    rd_word;
  logic                rd_hit;

  // One-hot read decode; out-of-range selects never match, so they are no-ops.
  always_comb begin
    rd_mask = '0;
    rd_word = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (rd_en && valid[i] && (32'(rd_sel) == i)) begin
        rd_mask[i] = 1'b1;
        rd_word    = chan[i];
      end
    end
  end

  assign rd_hit    = |rd_mask;
  assign any_valid = |valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        chan[i] <= '0;
      end
      valid    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_hit;
      if (rd_hit) begin
        rd_data <= rd_word;
      end
      // A load on the channel being read re-arms valid after the read clears it.
      valid <= (valid & ~rd_mask) | ld_en;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (ld_en[i]) begin
          chan[i] <= ld_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

`ifdef HOLD_REG_OVERRUN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= '0;
    end else begin
      overrun <= (overrun & ~{CHANNELS{ovr_clr}}) | (ld_en & valid & ~rd_mask);
    end
  end
`else
  logic unused_ovr_clr;
  assign unused_ovr_clr = ovr_clr;
  assign overrun        = '0;
`endif

endmodule

// File: tb/tb_hold_reg_bank.sv
// Self-checking bench for hold_reg_bank: directed vector table, reset corner cases,
// and randomized traffic compared against a behavioural model.
module tb_hold_reg_bank;

`ifdef HOLD_REG_OVERRUN_EN
  localparam logic OVR = 1'b1;
`else
  localparam logic OVR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ld_en;
  logic [31:0] ld_data;
  logic        rd_en;
  logic [1:0]  rd_sel;
  logic        ovr_clr;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [3:0]  valid;
  logic [3:0]  overrun;
  logic        any_valid;

  int errors = 0;
  int checks = 0;

  hold_reg_bank #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut (
    .clk(clk), .reset(reset), .ld_en(ld_en), .ld_data(ld_data),
    .rd_en(rd_en), .rd_sel(rd_sel), .ovr_clr(ovr_clr),
    .rd_data(rd_data), .rd_valid(rd_valid), .valid(valid),
    .overrun(overrun), .any_valid(any_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ld_en;
    logic [31:0] ld_data;
    logic        rd_en;
    logic [1:0]  rd_sel;
    logic        ovr_clr;
    logic [7:0]  e_rd_data;
    logic        e_rd_valid;
    logic [3:0]  e_valid;
    logic [3:0]  e_ovr;
  } vec_t;

  vec_t vecs[$];

  // behavioural model state
  logic [7:0] m_chan [4];
  logic [3:0] m_valid;
  logic [3:0] m_ovr;
  logic [7:0] m_rd_data;
  logic       m_rd_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] le, input logic [31:0] ld, input logic re,
                     input logic [1:0] rs, input logic oc, input logic [7:0] erd,
                     input logic erv, input logic [3:0] ev, input logic [3:0] eo);
    vec_t v;
    v.ld_en = le; v.ld_data = ld; v.rd_en = re; v.rd_sel = rs; v.ovr_clr = oc;
    v.e_rd_data = erd; v.e_rd_valid = erv; v.e_valid = ev; v.e_ovr = eo & {4{OVR}};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [3:0] le, input logic [31:0] ld, input logic re,
                       input logic [1:0] rs, input logic oc);
    @(negedge clk);
    ld_en = le; ld_data = ld; rd_en = re; rd_sel = rs; ovr_clr = oc;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_chan[i] = '0;
    m_valid = '0; m_ovr = '0; m_rd_data = '0; m_rd_valid = 1'b0;
  endtask

  // One clock edge of the model, derived directly from the read/load/overrun rules.
  task automatic model_edge(input logic [3:0] le, input logic [31:0] ld, input logic re,
                            input logic [1:0] rs, input logic oc);
    int  sel;
    bit  hit;
    sel = int'(rs);
    hit = re && sel < 4 && m_valid[sel];
    m_rd_valid = hit;
    if (hit) m_rd_data = m_chan[sel];
    if (OVR && oc) m_ovr = '0;
    for (int i = 0; i < 4; i++) begin
      if (le[i] && m_valid[i] && !(hit && sel == i) && OVR) m_ovr[i] = 1'b1;
    end
    if (hit) m_valid[sel] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (le[i]) begin
        m_valid[i] = 1'b1;
        m_chan[i]  = ld[i*8 +: 8];
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ld_en = '0; ld_data = '0; rd_en = 1'b0; rd_sel = '0; ovr_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1;
    ld_en = '0; ld_data = '0; rd_en = 1'b0; rd_sel = '0; ovr_clr = 1'b0;
    model_reset();

    // directed table: ld_en, ld_data, rd_en, rd_sel, ovr_clr | rd_data, rd_valid, valid, overrun
    add(4'b0001, 32'h000000A5, 0, 0, 0, 8'h00, 0, 4'b0001, 4'b0000);
    add(4'b0000, 32'h00000000, 1, 0, 0, 8'hA5, 1, 4'b0000, 4'b0000);
    add(4'b0000, 32'h00000000, 0, 0, 0, 8'hA5, 0, 4'b0000, 4'b0000);
    add(4'b0000, 32'h00000000, 1, 2, 0, 8'hA5, 0, 4'b0000, 4'b0000);
    add(4'b0010, 32'h00001100, 0, 0, 0, 8'hA5, 0, 4'b0010, 4'b0000);
    add(4'b0010, 32'h00002200, 0, 0, 0, 8'hA5, 0, 4'b0010, 4'b0010);
    add(4'b0000, 32'h00000000, 1, 1, 0, 8'h22, 1, 4'b0000, 4'b0010);
    add(4'b0000, 32'h00000000, 0, 0, 1, 8'h22, 0, 4'b0000, 4'b0000);
    add(4'b1000, 32'h33000000, 0, 0, 0, 8'h22, 0, 4'b1000, 4'b0000);
    add(4'b1000, 32'h44000000, 1, 3, 0, 8'h33, 1, 4'b1000, 4'b0000);
    add(4'b0000, 32'h00000000, 1, 3, 0, 8'h44, 1, 4'b0000, 4'b0000);
    add(4'b0001, 32'h00000001, 0, 0, 0, 8'h44, 0, 4'b0001, 4'b0000);
    add(4'b0001, 32'h00000002, 0, 0, 1, 8'h44, 0, 4'b0001, 4'b0001);
    add(4'b0000, 32'h00000000, 1, 0, 1, 8'h02, 1, 4'b0000, 4'b0000);

    #12;
    check("reset_rd_data", 32'(rd_data), 32'h0);
    check("reset_rd_valid", 32'(rd_valid), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    check("reset_any_valid", 32'(any_valid), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[k]) begin
      drive(vecs[k].ld_en, vecs[k].ld_data, vecs[k].rd_en, vecs[k].rd_sel, vecs[k].ovr_clr);
      check($sformatf("vec%0d_rd_data", k), 32'(rd_data), 32'(vecs[k].e_rd_data));
      check($sformatf("vec%0d_rd_valid", k), 32'(rd_valid), 32'(vecs[k].e_rd_valid));
      check($sformatf("vec%0d_valid", k), 32'(valid), 32'(vecs[k].e_valid));
      check($sformatf("vec%0d_overrun", k), 32'(overrun), 32'(vecs[k].e_ovr));
      check($sformatf("vec%0d_any_valid", k), 32'(any_valid), 32'(|vecs[k].e_valid));
    end

    // asynchronous reset mid-cycle after loading every channel
    drive(4'b1111, 32'h44332211, 0, 0, 0);
    drive(4'b1111, 32'h88776655, 1, 2, 0);
    check("preload_rd_data", 32'(rd_data), 32'h33);
    check("preload_valid", 32'(valid), 32'hF);
    check("preload_overrun", 32'(overrun), 32'(4'b1011 & {4{OVR}}));
    drive(4'b0000, 32'h0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(valid), 32'h0);
    check("async_rst_overrun", 32'(overrun), 32'h0);
    check("async_rst_rd_data", 32'(rd_data), 32'h0);
    check("async_rst_any_valid", 32'(any_valid), 32'h0);
    check("async_rst_rd_valid", 32'(rd_valid), 32'h0);
    #2;
    reset = 1'b0;
    drive(4'b0000, 32'h0, 1, 0, 0);
    check("post_rst_read_empty", 32'(rd_valid), 32'h0);
    drive(4'b0100, 32'h00C30000, 0, 0, 0);
    check("post_rst_load_valid", 32'(valid), 32'h4);
    drive(4'b0000, 32'h0, 1, 2, 0);
    check("post_rst_read_data", 32'(rd_data), 32'hC3);
    check("post_rst_read_valid", 32'(rd_valid), 32'h1);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [3:0]  le;
      logic [31:0] ld;
      logic        re;
      logic [1:0]  rs;
      logic        oc;
      le = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      ld = $urandom;
      re = 1'($urandom_range(0, 1));
      rs = 2'($urandom_range(0, 3));
      oc = ($urandom_range(0, 7) == 0);
      drive(le, ld, re, rs, oc);
      model_edge(le, ld, re, rs, oc);
      check($sformatf("rand%0d_rd_valid", n), 32'(rd_valid), 32'(m_rd_valid));
      check($sformatf("rand%0d_rd_data", n), 32'(rd_data), 32'(m_rd_data));
      check($sformatf("rand%0d_valid", n), 32'(valid), 32'(m_valid));
      check($sformatf("rand%0d_overrun", n), 32'(overrun), 32'(m_ovr));
      check($sformatf("rand%0d_any_valid", n), 32'(any_valid), 32'(|m_valid));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
